// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths, register-index width and ALU opcode encodings for the operand fetch stage
// and the ALU it feeds.
package operand_fetch_stage_pkg;

   localparam int unsigned DWIDTH = 8;
   localparam int unsigned NREGS  = 8;
   localparam int unsigned REG_AW = $clog2(NREGS);

   typedef enum logic [2:0] {
      AluFwd   = 3'b000,
      AluAdd   = 3'b001,
      AluAnd   = 3'b010,
      AluOr    = 3'b011,
      AluMul   = 3'b100,
      AluShift = 3'b101
   } aluop_e;

   function automatic logic [DWIDTH-1:0] twos_neg(input logic [DWIDTH-1:0] v);
      return ~v + DWIDTH'(1);
   endfunction

endpackage

// File: rtl/operand_fetch_stage_reg_file.sv
// NREGS x DWIDTH general register file: two asynchronous read ports, one synchronous write
// port, asynchronous active-low clear.
module operand_fetch_stage_reg_file
   import operand_fetch_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] raddr1,
   output logic [DWIDTH-1:0] rdata1,
   input  logic [REG_AW-1:0] raddr2,
   output logic [DWIDTH-1:0] rdata2,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DWIDTH-1:0] wdata
);

   logic [DWIDTH-1:0] regs_q [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we) begin
         regs_q[waddr] <= wdata;
      end
   end

   assign rdata1 = regs_q[raddr1];
   assign rdata2 = regs_q[raddr2];

endmodule

// File: rtl/operand_fetch_stage.sv
// Register-read / operand-prepare stage feeding the ALU through one valid/ready slot.
// Define OFS_BYPASS_EN to forward a same-edge register write into the captured operands.
module operand_fetch_stage
   import operand_fetch_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [REG_AW-1:0] readreg1,
   input  logic [REG_AW-1:0] readreg2,
   input  logic [DWIDTH-1:0] immediate,
   input  logic              imm_sel,
   input  logic              sub_sel,
   input  logic [2:0]        aluop_in,
   input  logic              writeenable,
   input  logic [REG_AW-1:0] writereg,
   input  logic [DWIDTH-1:0] writedata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] data1,
   output logic [DWIDTH-1:0] data2,
   output logic [2:0]        aluop
);

   typedef enum logic {StEmpty, StFull} slot_state_e;

   slot_state_e       state_q;
   logic [DWIDTH-1:0] data1_q, data2_q;
   logic [2:0]        aluop_q;

   logic [DWIDTH-1:0] rdata1, rdata2;
   logic [DWIDTH-1:0] op1, src_reg, src, op2;
   logic              accept;

   operand_fetch_stage_reg_file u_reg_file (
      .clk    (clk),
      .rst_n  (rst_n),
      .raddr1 (readreg1),
      .rdata1 (rdata1),
      .raddr2 (readreg2),
      .rdata2 (rdata2),
      .we     (writeenable),
      .waddr  (writereg),
      .wdata  (writedata)
   );

`ifdef OFS_BYPASS_EN
   assign op1     = (writeenable && (writereg == readreg1)) ? writedata : rdata1;
   assign src_reg = (writeenable && (writereg == readreg2)) ? writedata : rdata2;
`else
   assign op1     = rdata1;
   assign src_reg = rdata2;
`endif

   // Negation follows the bypass so a forwarded value is negated like an array value.
   assign src = imm_sel ? immediate : src_reg;
   assign op2 = sub_sel ? twos_neg(src) : src;

   assign out_valid = (state_q == StFull);
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StEmpty;
         data1_q <= '0;
         data2_q <= '0;
         aluop_q <= '0;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (accept) begin
                  state_q <= StFull;
                  data1_q <= op1;
                  data2_q <= op2;
                  aluop_q <= aluop_in;
               end
            end
            StFull: begin
               if (accept) begin
                  data1_q <= op1;
                  data2_q <= op2;
                  aluop_q <= aluop_in;
               end else if (out_ready) begin
                  state_q <= StEmpty;
               end
            end
            default: state_q <= StEmpty;
         endcase
      end
   end

   assign data1 = data1_q;
   assign data2 = data2_q;
   assign aluop = aluop_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed and table-driven bench for operand_fetch_stage, plus a short randomised stream
// checked against a register-array model.
module tb_operand_fetch_stage;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready;
   logic [2:0] readreg1, readreg2, aluop_in, writereg, aluop;
   logic [7:0] immediate, writedata, data1, data2;
   logic       imm_sel, sub_sel, writeenable, out_valid, out_ready;

   always #5 clk = ~clk;

   operand_fetch_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .readreg1    (readreg1),
      .readreg2    (readreg2),
      .immediate   (immediate),
      .imm_sel     (imm_sel),
      .sub_sel     (sub_sel),
      .aluop_in    (aluop_in),
      .writeenable (writeenable),
      .writereg    (writereg),
      .writedata   (writedata),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .data1       (data1),
      .data2       (data2),
      .aluop       (aluop)
   );

   typedef struct {
      logic [2:0] r1;
      logic [2:0] r2;
      logic [7:0] imm;
      logic       isel;
      logic       ssel;
      logic [2:0] op;
      logic [7:0] e1;
      logic [7:0] e2;
   } vec_t;

   vec_t       vecs [9];
   logic [7:0] model_r [8];
   int         n_pass  = 0;
   int         n_total = 0;

   // stream stimulus and expectations
   logic [2:0] s_r1 [20], s_r2 [20], s_op [20];
   logic [7:0] s_imm [20], s_e1 [20], s_e2 [20];
   logic       s_isel [20], s_ssel [20];

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] r1, input logic [2:0] r2, input logic [7:0] imm,
                        input logic isel, input logic ssel, input logic [2:0] op);
      in_valid  = 1'b1;
      readreg1  = r1;
      readreg2  = r2;
      immediate = imm;
      imm_sel   = isel;
      sub_sel   = ssel;
      aluop_in  = op;
   endtask

   task automatic write_reg(input logic [2:0] r, input logic [7:0] d);
      writeenable = 1'b1;
      writereg    = r;
      writedata   = d;
      tick();
      writeenable = 1'b0;
      model_r[r]  = d;
   endtask

   task automatic check_slot(input string tag, input logic v, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [2:0] op);
      check({tag, "_valid"}, out_valid, v);
      check({tag, "_d1"}, data1, e1);
      check({tag, "_d2"}, data2, e2);
      check({tag, "_op"}, aluop, op);
   endtask

   function automatic logic [7:0] neg(input logic [7:0] v);
      logic [8:0] t;
      t = 9'h100 - {1'b0, v};
      return t[7:0];
   endfunction

   initial begin
      int idx, k, cyc;
      logic acc;
      logic [7:0] src;

      //             r1    r2    imm    isel  ssel  op    e1     e2
      vecs[0] = '{3'd3, 3'd0, 8'h10, 1'b1, 1'b1, 3'd1, 8'h25, 8'hF0};
      vecs[1] = '{3'd0, 3'd5, 8'h00, 1'b0, 1'b0, 3'd2, 8'h5A, 8'hFF};
      vecs[2] = '{3'd7, 3'd1, 8'h00, 1'b0, 1'b1, 3'd3, 8'h7F, 8'hFF};
      vecs[3] = '{3'd4, 3'd0, 8'h80, 1'b1, 1'b1, 3'd4, 8'h80, 8'h80};
      vecs[4] = '{3'd1, 3'd0, 8'h00, 1'b1, 1'b1, 3'd5, 8'h01, 8'h00};
      vecs[5] = '{3'd6, 3'd4, 8'h00, 1'b0, 1'b1, 3'd0, 8'h3C, 8'h80};
      vecs[6] = '{3'd5, 3'd6, 8'h00, 1'b0, 1'b1, 3'd1, 8'hFF, 8'hC4};
      vecs[7] = '{3'd2, 3'd3, 8'h7F, 1'b1, 1'b0, 3'd6, 8'h11, 8'h7F};
      vecs[8] = '{3'd3, 3'd2, 8'h00, 1'b0, 1'b1, 3'd2, 8'h25, 8'hEF};

      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; writeenable = 1'b0;
      readreg1 = '0; readreg2 = '0; immediate = '0; imm_sel = 1'b0; sub_sel = 1'b0;
      aluop_in = '0; writereg = '0; writedata = '0;
      tick();
      tick();
      check_slot("reset", 1'b0, 8'h00, 8'h00, 3'd0);
      rst_n = 1'b1;
      tick();

      write_reg(3'd0, 8'h5A); write_reg(3'd1, 8'h01); write_reg(3'd2, 8'h11);
      write_reg(3'd3, 8'h25); write_reg(3'd4, 8'h80); write_reg(3'd5, 8'hFF);
      write_reg(3'd6, 8'h3C); write_reg(3'd7, 8'h7F);

      // back-to-back table issue, ALU side always ready
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].r1, vecs[i].r2, vecs[i].imm, vecs[i].isel, vecs[i].ssel, vecs[i].op);
         tick();
         check_slot($sformatf("vec%0d", i), 1'b1, vecs[i].e1, vecs[i].e2, vecs[i].op);
      end
      in_valid = 1'b0;
      tick();
      check("drain_valid", out_valid, 0);

      // stall: A held for 3 cycles while B waits and R3 is rewritten underneath
      out_ready = 1'b0;
      drive(3'd3, 3'd0, 8'h10, 1'b1, 1'b1, 3'd1);
      tick();
      drive(3'd6, 3'd5, 8'h00, 1'b0, 1'b0, 3'd4);
      for (int s = 0; s < 3; s++) begin
         writeenable = (s == 0);
         writereg    = 3'd3;
         writedata   = 8'h99;
         tick();
         writeenable = 1'b0;
         check($sformatf("stall%0d_in_ready", s), in_ready, 0);
         check_slot($sformatf("stall%0d", s), 1'b1, 8'h25, 8'hF0, 3'd1);
      end
      model_r[3] = 8'h99;
      out_ready = 1'b1;
      #1;
      check("unstall_in_ready", in_ready, 1);
      tick();
      check_slot("after_stall", 1'b1, 8'h3C, 8'hFF, 3'd4);
      in_valid = 1'b0;
      tick();
      check("after_stall_drain", out_valid, 0);

      // same-edge write and read of R2 (prior value 0x11)
      writeenable = 1'b1; writereg = 3'd2; writedata = 8'h7A;
      drive(3'd2, 3'd0, 8'h00, 1'b1, 1'b0, 3'd0);
      tick();
      writeenable = 1'b0;
`ifdef OFS_BYPASS_EN
      check("same_edge_d1", data1, 8'h7A);
`else
      check("same_edge_d1", data1, 8'h11);
`endif
      model_r[2] = 8'h7A;
      tick();
      check("after_write_d1", data1, 8'h7A);
      in_valid = 1'b0;
      tick();

      // random stream with random back-pressure
      for (int i = 0; i < 20; i++) begin
         s_r1[i]   = 3'($urandom_range(0, 7));
         s_r2[i]   = 3'($urandom_range(0, 7));
         s_imm[i]  = 8'($urandom_range(0, 255));
         s_isel[i] = 1'($urandom_range(0, 1));
         s_ssel[i] = 1'($urandom_range(0, 1));
         s_op[i]   = 3'($urandom_range(0, 5));
         src       = s_isel[i] ? s_imm[i] : model_r[s_r2[i]];
         s_e1[i]   = model_r[s_r1[i]];
         s_e2[i]   = s_ssel[i] ? neg(src) : src;
      end
      idx = 0;
      k   = 0;
      cyc = 0;
      while (k < 20 && cyc < 400) begin
         out_ready = 1'($urandom_range(0, 1));
         if (idx < 20) drive(s_r1[idx], s_r2[idx], s_imm[idx], s_isel[idx], s_ssel[idx],
                             s_op[idx]);
         else in_valid = 1'b0;
         #1;
         if (out_valid && out_ready) begin
            check($sformatf("stream%0d_d1", k), data1, s_e1[k]);
            check($sformatf("stream%0d_d2", k), data2, s_e2[k]);
            check($sformatf("stream%0d_op", k), aluop, s_op[k]);
            k++;
         end
         acc = in_valid && in_ready;
         tick();
         if (acc) idx++;
         cyc++;
      end
      in_valid = 1'b0;
      check("stream_count", k, 20);
      check("stream_empty", out_valid, 0);

      // asynchronous reset with a full slot; writes during reset are dropped
      out_ready = 1'b0;
      drive(3'd5, 3'd4, 8'h00, 1'b0, 1'b1, 3'd3);
      tick();
      rst_n = 1'b0;
      #1;
      check_slot("midrst", 1'b0, 8'h00, 8'h00, 3'd0);
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         writeenable = 1'b1;
         writereg    = 3'(i);
         writedata   = 8'hFF;
         tick();
      end
      writeenable = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(3'(i), 3'd0, 8'h00, 1'b1, 1'b0, 3'd0);
         tick();
         check($sformatf("rd%0d_after_reset", i), data1, 8'h00);
      end
      in_valid = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
